jt7759_rom_arb: RTL and testbench
=================================

JT7759_ROM_ARB -- requirements
Module: jt7759_rom_arb

Interface
REQ-001 SHALL have parameter AW, default 17, giving the ROM byte-address width for both requesters and the memory port.
REQ-002 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports req0_cs / req1_cs  input  1  requester read strobe, matching the jt7759 rom_cs output.
REQ-005 SHALL have ports req0_addr / req1_addr  input  AW  requester byte address.
REQ-006 SHALL have ports req0_data / req1_data  output  8  returned byte.
REQ-007 SHALL have ports req0_ok / req1_ok  output  1  high when reqN_data is valid for the current reqN_addr.
REQ-008 SHALL have port mem_cs  output  1  memory read request.
REQ-009 SHALL have port mem_addr  output  AW  memory address.
REQ-010 SHALL have port mem_data  input  8  memory read data.
REQ-011 SHALL have port mem_ok  input  1  mem_data valid for mem_addr.

Function
REQ-012 SHALL keep one entry per requester: tag (AW bits), data (8 bits) and valid bit.
REQ-013 SHALL drive reqN_ok = reqN_cs & validN & (tagN == reqN_addr), combinationally; reqN_data = dataN at all times.
REQ-014 SHALL treat reqN_cs high with reqN_ok low as a pending miss.
REQ-015 SHALL implement FSM states IDLE, FETCH0, FETCH1.
REQ-016 IDLE: one miss pending -> FETCHn; both pending -> grant the requester not served last (round-robin pointer, reset value: requester 0 wins).
REQ-017 Entering FETCHn SHALL latch reqN_addr into mem_addr and set mem_cs high on the next clock edge (registered, 1-cycle latency from the miss).
REQ-018 In FETCHn, mem_addr and mem_cs SHALL stay constant until mem_ok is sampled high.
REQ-019 On mem_ok in FETCHn: tagN <= mem_addr, dataN <= mem_data, validN <= 1, pointer <= n, mem_cs <= 0, state <= IDLE; reqN_ok is therefore high the cycle after mem_ok if the address is unchanged.
REQ-020 mem_cs SHALL be low for at least one cycle between consecutive fetches (IDLE lasts one cycle minimum).
REQ-021 Requester address change or cs drop during FETCHn SHALL NOT abort the fetch; the fetched byte is stored under the latched address and a new miss is raised if still mismatched.
REQ-022 mem_ok while in IDLE SHALL be ignored.
REQ-023 A requester whose miss is pending SHALL be granted within one fetch of the other requester (no starvation).
REQ-024 Address compare SHALL use all AW bits; no wrap or partial match.

Reset
REQ-025 On rst high at a clock edge: state IDLE, mem_cs 0, mem_addr 0, valid0/valid1 0, tags 0, data 0, pointer selects requester 0 first.
REQ-026 rst mid-fetch SHALL drop mem_cs on the same edge and discard the outstanding fetch; a later mem_ok SHALL be ignored.

Configuration
REQ-027 Macro JT7759_ARB_CACHE_EN defined: entries persist after reqN_cs falls; a later request to the same address hits with no memory access.
REQ-028 Macro undefined: validN SHALL be cleared on any cycle where reqN_cs is low, so each new cs assertion fetches from memory.

Verification
REQ-029 Single miss: req0_cs=1, addr=0x00123, mem_ok 3 cycles after mem_cs, mem_data=0xA5 -> mem_cs 1 cycle after the request, req0_ok=1 and req0_data=0xA5 the cycle after mem_ok.
REQ-030 Simultaneous misses after reset: req0 addr 0x00010, req1 addr 0x00020 -> mem_addr 0x00010 first, then 0x00020, with mem_cs low one cycle in between.
REQ-031 Round-robin: after the REQ-030 fetches, both miss again at 0x00011/0x00021 -> requester 1 is not favoured twice; order is 0x00011 then 0x00021.
REQ-032 Cache toggle: fetch 0x1FFFF, drop cs, reassert same address -> with JT7759_ARB_CACHE_EN req0_ok same cycle, no mem_cs; without it, a new fetch occurs.
REQ-033 Address change mid-fetch: req1 addr 0x00040 -> 0x00041 before mem_ok -> req1_ok stays low, then a second fetch at 0x00041 completes.
REQ-034 Reset mid-fetch: rst pulse while mem_cs=1, then mem_ok=1 -> mem_cs 0 after the reset edge, both valid bits 0, no reqN_ok asserted.

Source files
------------

// File: rtl/jt7759_rom_arb.sv
// jt7759_rom_arb
//   Shares one byte-wide ROM port between two jt7759-style requesters. Each
//   requester has a one-entry cache of tag/data/valid. A requester holding
//   cs with no matching valid entry is a pending miss. An FSM serves the
//   misses one at a time and uses round-robin when both are pending.
//
//   Build option: JT7759_ARB_CACHE_EN
//     defined   - entries persist after reqN_cs falls. A repeat read of the
//                 same address hits without a memory access.
//     undefined - an entry is invalidated on every cycle where its cs is
//                 low, so each new cs assertion fetches from memory.
//
// Ports
//   clk, rst               clock and synchronous active-high reset
//   reqN_cs / reqN_addr    requester read strobe and byte address (N = 0, 1)
//   reqN_data / reqN_ok    cached byte, and the hit flag for the current address
//   mem_cs / mem_addr      registered memory read request and address
//   mem_data / mem_ok      memory read data and its valid strobe
module jt7759_rom_arb #(
  parameter int unsigned AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_cs,
  input  logic [AW-1:0] req0_addr,
  output logic [7:0]    req0_data,
  output logic          req0_ok,
  input  logic          req1_cs,
  input  logic [AW-1:0] req1_addr,
  output logic [7:0]    req1_data,
  output logic          req1_ok,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  input  logic          mem_ok
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] tag0_q, tag1_q;
  logic [7:0]    data0_q, data1_q;
  logic          valid0_q, valid1_q;
  logic          last_q;      // requester served most recently
  logic          mem_cs_q;
  logic [AW-1:0] mem_addr_q;

  logic hit0, hit1, miss0, miss1, pick1;

  assign hit0  = valid0_q && (tag0_q == req0_addr);
  assign hit1  = valid1_q && (tag1_q == req1_addr);
  assign miss0 = req0_cs && !hit0;
  assign miss1 = req1_cs && !hit1;
  // Requester 1 wins when it is the only miss, or when both miss and
  // requester 0 was served last.
  assign pick1 = miss1 && (!miss0 || !last_q);

  assign req0_ok   = req0_cs && hit0;
  assign req1_ok   = req1_cs && hit1;
  assign req0_data = data0_q;
  assign req1_data = data1_q;
  assign mem_cs    = mem_cs_q;
  assign mem_addr  = mem_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tag0_q     <= '0;
      tag1_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      last_q     <= 1'b1;     // requester 0 wins the first tie
      mem_cs_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // mem_ok is ignored here; each entry into IDLE keeps mem_cs low
          // for at least one cycle.
          if (miss0 || miss1) begin
            mem_cs_q <= 1'b1;
            if (pick1) begin
              state_q    <= FETCH1;
              mem_addr_q <= req1_addr;
            end else begin
              state_q    <= FETCH0;
              mem_addr_q <= req0_addr;
            end
          end
        end
        FETCH0: begin
          if (mem_ok) begin
            tag0_q   <= mem_addr_q;
            data0_q  <= mem_data;
            valid0_q <= 1'b1;
            last_q   <= 1'b0;
            mem_cs_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        FETCH1: begin
          if (mem_ok) begin
            tag1_q   <= mem_addr_q;
            data1_q  <= mem_data;
            valid1_q <= 1'b1;
            last_q   <= 1'b1;
            mem_cs_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_cs_q <= 1'b0;
        end
      endcase
`ifdef JT7759_ARB_CACHE_EN
      // Entries stay valid while cs is low.
`else
      // These assignments come after the fetch completion, so the clear
      // takes priority when a fetch completes in a cycle where cs is low.
      if (!req0_cs) valid0_q <= 1'b0;
      if (!req1_cs) valid1_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_jt7759_rom_arb.sv
// tb_jt7759_rom_arb
//   Bench for jt7759_rom_arb. The expected memory fetch addresses are queued
//   when the requests are driven. A monitor pops the queue on each rising
//   edge of mem_cs. A behavioural ROM answers mem_cs after a fixed latency.
module tb_jt7759_rom_arb;
  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_cs, req1_cs;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [7:0]    req0_data, req1_data;
  logic          req0_ok, req1_ok;
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_ok;

  int n_tests = 0;
  int n_fail  = 0;
  int spurious = 0;
  int cyc = 0;
  int ok_edge = 0;
  bit resp_en;
  int resp_lat;
  logic [AW-1:0] exp_q[$];

  jt7759_rom_arb #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_cs   (req0_cs),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ok   (req0_ok),
    .req1_cs   (req1_cs),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ok   (req1_ok),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ok    (mem_ok)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mdata(input logic [AW-1:0] a);
    if (a == 17'h00123) return 8'hA5;
    return a[7:0] ^ a[16:9] ^ 8'h3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ok(input bit n, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      seen = n ? req1_ok : req0_ok;
    end
    check({tag, "_ok"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_cs(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      seen = mem_cs;
    end
    check({tag, "_cs"}, {31'd0, seen}, 32'd1);
  endtask

  // Behavioural ROM: it answers resp_lat cycles after mem_cs rises with a
  // one-cycle mem_ok pulse.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        cnt = 0;
      end else if (mem_ok) begin
        mem_ok = 1'b0;
        cnt = 0;
      end else if (mem_cs) begin
        if (cnt == resp_lat) begin
          mem_ok   = 1'b1;
          mem_data = mdata(mem_addr);
          ok_edge  = cyc + 1;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Fetch monitor: checks each new fetch address against the queue, and
  // checks that the address holds while mem_cs stays high.
  initial begin
    logic          prev_cs;
    logic [AW-1:0] held;
    prev_cs = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (mem_cs && !prev_cs) begin
        if (exp_q.size() == 0) spurious++;
        else check("fetch_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
        held = mem_addr;
      end else if (mem_cs) begin
        check("addr_hold", 32'(mem_addr), 32'(held));
      end
      prev_cs = mem_cs;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_cs = 1'b1; req1_cs = 1'b1;
    req0_addr = '0; req1_addr = '0;
    mem_ok = 1'b0; mem_data = '0;
    resp_en = 1'b1; resp_lat = 3;

    // Reset state. The requesters hold address 0 with cs high, so this also
    // checks that both valid bits are cleared.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_ok0", 32'(req0_ok), 32'd0);
    check("rst_ok1", 32'(req1_ok), 32'd0);
    check("rst_data0", 32'(req0_data), 32'd0);
    check("rst_data1", 32'(req1_data), 32'd0);
    rst = 1'b0; req0_cs = 1'b0; req1_cs = 1'b0;
    @(posedge clk); #1;

    // Single miss
    req0_cs = 1'b1; req0_addr = 17'h00123;
    exp_q.push_back(17'h00123);
    #1 check("r29_miss_ok", 32'(req0_ok), 32'd0);
    @(posedge clk); #1;
    check("r29_cs_lat", 32'(mem_cs), 32'd1);
    check("r29_addr", 32'(mem_addr), 32'h00123);
    wait_ok(1'b0, 20, "r29");
    check("r29_ok_timing", 32'(cyc), 32'(ok_edge));
    check("r29_data", 32'(req0_data), 32'hA5);
    req0_cs = 1'b0;
    @(posedge clk); #1;

    // Simultaneous misses right after reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0_cs = 1'b1; req0_addr = 17'h00010;
    req1_cs = 1'b1; req1_addr = 17'h00020;
    exp_q.push_back(17'h00010);
    exp_q.push_back(17'h00020);
    wait_ok(1'b0, 20, "r30_0");
    check("r30_data0", 32'(req0_data), 32'(mdata(17'h00010)));
    check("r30_gap", 32'(mem_cs), 32'd0);
    wait_ok(1'b1, 20, "r30_1");
    check("r30_data1", 32'(req1_data), 32'(mdata(17'h00020)));

    // Round-robin: requester 1 was served last, so requester 0 goes first
    req0_addr = 17'h00011; req1_addr = 17'h00021;
    exp_q.push_back(17'h00011);
    exp_q.push_back(17'h00021);
    wait_ok(1'b0, 20, "r31_0");
    check("r31_pending1", 32'(req1_ok), 32'd0);
    wait_ok(1'b1, 20, "r31_1");
    check("r31_data1", 32'(req1_data), 32'(mdata(17'h00021)));
    req0_cs = 1'b0; req1_cs = 1'b0;
    @(posedge clk); #1;

    // Address change mid-fetch: the first fetch completes, then a second
    // fetch runs for the new address.
    req1_cs = 1'b1; req1_addr = 17'h00040;
    exp_q.push_back(17'h00040);
    exp_q.push_back(17'h00041);
    wait_cs(10, "r33");
    req1_addr = 17'h00041;
    wait_ok(1'b1, 30, "r33");
    check("r33_data", 32'(req1_data), 32'(mdata(17'h00041)));
    check("r33_both_fetched", 32'(exp_q.size()), 32'd0);
    req1_cs = 1'b0;
    @(posedge clk); #1;

    // Top address, then cs drop and reassert
    req0_cs = 1'b1; req0_addr = 17'h1FFFF;
    exp_q.push_back(17'h1FFFF);
    wait_ok(1'b0, 20, "r32_first");
    check("r32_data", 32'(req0_data), 32'(mdata(17'h1FFFF)));
    req0_cs = 1'b0;
    @(posedge clk); #1;
    req0_cs = 1'b1;
    #1;
`ifdef JT7759_ARB_CACHE_EN
    check("r32_hit", 32'(req0_ok), 32'd1);
    check("r32_hit_data", 32'(req0_data), 32'(mdata(17'h1FFFF)));
    @(posedge clk); #1;
    check("r32_no_fetch", 32'(mem_cs), 32'd0);
`else
    check("r32_refetch_miss", 32'(req0_ok), 32'd0);
    exp_q.push_back(17'h1FFFF);
    wait_ok(1'b0, 20, "r32_refetch");
    check("r32_refetch_data", 32'(req0_data), 32'(mdata(17'h1FFFF)));
`endif
    // The compare uses every address bit, so 0x0FFFF misses against 0x1FFFF
    req0_addr = 17'h0FFFF;
    #1 check("r24_full_cmp", 32'(req0_ok), 32'd0);
    req0_cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("r32_idle_spurious", 32'(spurious), 32'd0);

    // Reset mid-fetch. The ROM is driven by hand here.
    resp_en = 1'b0;
    req1_cs = 1'b1; req1_addr = 17'h00055;
    exp_q.push_back(17'h00055);
    @(posedge clk); #1;
    check("r34_cs_up", 32'(mem_cs), 32'd1);
    rst = 1'b1; req1_cs = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("r34_cs_drop", 32'(mem_cs), 32'd0);
    mem_ok = 1'b1; mem_data = 8'h99;
    @(posedge clk); #1;
    mem_ok = 1'b0;
    check("r34_idle_mem_ok", 32'(mem_cs), 32'd0);
    req0_cs = 1'b1; req0_addr = 17'h1FFFF;
    req1_cs = 1'b1; req1_addr = 17'h00055;
    #1;
    check("r34_ok0", 32'(req0_ok), 32'd0);
    check("r34_ok1", 32'(req1_ok), 32'd0);
    resp_en = 1'b1;
    exp_q.push_back(17'h1FFFF);
    exp_q.push_back(17'h00055);
    wait_ok(1'b0, 20, "r34_0");
    wait_ok(1'b1, 20, "r34_1");
    check("r34_data1", 32'(req1_data), 32'(mdata(17'h00055)));
    req0_cs = 1'b0; req1_cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("spurious_fetches", 32'(spurious), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
